// File: rtl/forward_pkg.sv
// Shared defaults and slice helper for the operand-bypass / hazard unit.
// Optional feature macro: FORWARD_STALL_COUNT_EN (see forward_scoreboard).
package forward_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/forward_port_mux.sv
// Priority bypass search for one consumer operand port.
// Youngest stage first, then the returning long-latency result, then the RF.
module forward_port_mux
    import forward_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_STAGES = 3
) (
    input  logic [REG_ADDR_W-1:0]            rs_i,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_rd_i,
    input  logic [NUM_STAGES*XLEN-1:0]       stage_data_i,
    input  logic [NUM_STAGES-1:0]            stage_wen_i,
    input  logic [NUM_STAGES-1:0]            stage_ready_i,
    input  logic                             lp_done_i,
    input  logic [REG_ADDR_W-1:0]            lp_done_rd_i,
    input  logic [XLEN-1:0]                  lp_done_data_i,
    input  logic [XLEN-1:0]                  rf_data_i,
    output logic [XLEN-1:0]                  operand_o,
    output logic                             hit_not_ready_o
);

    logic found;

    // rs_i != 0 on the search path, so stages targeting x0 can never match.
    always_comb begin
        operand_o       = rf_data_i;
        hit_not_ready_o = 1'b0;
        found           = 1'b0;
        if (rs_i == '0) begin
            operand_o = '0;
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (!found && stage_wen_i[s] &&
                    stage_rd_i[slice_lo(s, REG_ADDR_W) +: REG_ADDR_W] == rs_i) begin
                    found           = 1'b1;
                    operand_o       = stage_data_i[slice_lo(s, XLEN) +: XLEN];
                    hit_not_ready_o = !stage_ready_i[s];
                end
            end
            if (!found && lp_done_i && lp_done_rd_i == rs_i) begin
                operand_o = lp_done_data_i;
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Decode-stage operand bypass, long-latency scoreboard and stall generation.
// Define FORWARD_STALL_COUNT_EN to add the saturating stall_cycles counter.
module forward_scoreboard
    import forward_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int NUM_STAGES     = 3,
    parameter int NUM_READ_PORTS = 2,
    localparam int REG_COUNT     = 2 ** REG_ADDR_W
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0]     stage_rd,
    input  logic [NUM_STAGES*XLEN-1:0]           stage_data,
    input  logic [NUM_STAGES-1:0]                stage_wen,
    input  logic [NUM_STAGES-1:0]                stage_ready,
    input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rs,
    input  logic [NUM_READ_PORTS-1:0]            rs_used,
    input  logic [NUM_READ_PORTS*XLEN-1:0]       rf_data,
    output logic [NUM_READ_PORTS*XLEN-1:0]       operand,
    input  logic [REG_ADDR_W-1:0]                dst_rd,
    input  logic                                 dst_used,
    input  logic                                 lp_issue,
    input  logic                                 lp_done,
    input  logic [REG_ADDR_W-1:0]                lp_done_rd,
    input  logic [XLEN-1:0]                      lp_done_data,
    output logic                                 stall,
`ifdef FORWARD_STALL_COUNT_EN
    output logic [31:0]                          stall_cycles,
`endif
    output logic [REG_COUNT-1:0]                 pending
);

    logic [REG_COUNT-1:0]      pending_q;
    logic [REG_COUNT-1:0]      pending_d;
    logic [NUM_READ_PORTS-1:0] hnr;
    logic [NUM_READ_PORTS-1:0] port_haz;
    logic                      waw_haz;

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        localparam int RLO = slice_lo(p, REG_ADDR_W);
        localparam int DLO = slice_lo(p, XLEN);

        forward_port_mux #(
            .XLEN       (XLEN),
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_STAGES (NUM_STAGES)
        ) u_mux (
            .rs_i           (rs[RLO +: REG_ADDR_W]),
            .stage_rd_i     (stage_rd),
            .stage_data_i   (stage_data),
            .stage_wen_i    (stage_wen),
            .stage_ready_i  (stage_ready),
            .lp_done_i      (lp_done),
            .lp_done_rd_i   (lp_done_rd),
            .lp_done_data_i (lp_done_data),
            .rf_data_i      (rf_data[DLO +: XLEN]),
            .operand_o      (operand[DLO +: XLEN]),
            .hit_not_ready_o(hnr[p])
        );

        // A result returning this cycle is bypassed, so it resolves the hazard.
        assign port_haz[p] = rs_used[p] &
            (hnr[p] | (pending_q[rs[RLO +: REG_ADDR_W]] &
                       !(lp_done && lp_done_rd == rs[RLO +: REG_ADDR_W])));
    end

    assign waw_haz = dst_used & pending_q[dst_rd] &
                     !(lp_done && lp_done_rd == dst_rd);

    assign stall   = (|port_haz) | waw_haz;
    assign pending = pending_q;

    // Clear first so a same-cycle set on the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (lp_done) begin
            pending_d[lp_done_rd] = 1'b0;
        end
        if (lp_issue && !stall && dst_used && dst_rd != '0) begin
            pending_d[dst_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef FORWARD_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    assign stall_cnt_d  = (stall && stall_cnt_q != 32'hFFFF_FFFF) ?
                          stall_cnt_q + 32'd1 : stall_cnt_q;
    assign stall_cycles = stall_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
